mmio_uart_tx: RTL

- Memory-mapped transmit peripheral on the data-memory side of the pipeline, beside dmem.
- Watches the processor's M-stage store bus (MemWriteM, DataAdrM, WriteDataM) and queues bytes written to a TX data address in a small FIFO.
- Serialises queued bytes as 8N1 frames on a single output line.
- Drives a combinational status word for a read mux ahead of ReadDataM, so software can poll.

---
 rtl/mmio_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 72 +++++++
 rtl/mmio_uart_tx.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
//   - default store / status addresses
//   - status word bit positions
//   - serialiser FSM state encoding
package mmio_pkg;

    localparam logic [31:0] TX_ADDR_DEF   = 32'hFFFF_FF00;
    localparam logic [31:0] STAT_ADDR_DEF = 32'hFFFF_FF04;

    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with first-word fall-through output.
// Ports:
//   clk, reset     rising-edge clock, async active-high reset
//   push, din      write request and data (ignored when full unless popping)
//   pop            read request (ignored when empty)
//   dout           current head entry
//   count          occupancy, 0..DEPTH
//   full, empty    occupancy flags
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // A push into a full FIFO is still legal when the head leaves on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; emptiness is tracked by count_q.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter snooping the M-stage store bus.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high); pops the next byte directly into START if one waits
//
// Ports:
//   clk, reset                   rising-edge clock, async active-high reset
//   MemWriteM, DataAdrM, WriteDataM  M-stage store bus
//   stat_sel                     DataAdrM hits the status address
//   stat_rdata                   {28'b0, overflow, busy, full, empty}
//   tx                           registered serial line, idles high
//   tx_busy                      registered, high while a frame is in flight
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter logic [31:0] TX_ADDR      = TX_ADDR_DEF,
    parameter logic [31:0] STAT_ADDR    = STAT_ADDR_DEF,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic [31:0] DataAdrM,
    input  logic [31:0] WriteDataM,
    output logic        stat_sel,
    output logic [31:0] stat_rdata,
    output logic        tx,
    output logic        tx_busy
);

    localparam int          BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;

    tx_state_e     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          ovf_q, ovf_d;

    logic          push_req, ovf_clr, ovf_set;
    logic          fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] unused_fifo_count;
    logic          unused_wdata;
    logic          baud_end;

    assign unused_wdata = ^WriteDataM[31:8];

    assign push_req = MemWriteM && (DataAdrM == TX_ADDR);
    assign ovf_clr  = MemWriteM && (DataAdrM == STAT_ADDR) && WriteDataM[3];
    assign ovf_set  = push_req && fifo_full && !fifo_pop;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (fifo_pop),
        .din   (WriteDataM[7:0]),
        .dout  (fifo_dout),
        .count (unused_fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign stat_sel = (DataAdrM == STAT_ADDR);

    always_comb begin
        stat_rdata           = '0;
        stat_rdata[ST_EMPTY] = fifo_empty;
        stat_rdata[ST_FULL]  = fifo_full;
        stat_rdata[ST_BUSY]  = busy_q;
        stat_rdata[ST_OVF]   = ovf_q;
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;

    // A fresh overflow on the clearing edge wins.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (ovf_set) ovf_d = 1'b1;
    end

    assign baud_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    sh_d     = fifo_dout;
                    baud_d   = '0;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = sh_q[0];
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    sh_d   = {1'b0, sh_q[7:1]};
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = sh_q[1];
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        sh_d     = fifo_dout;
                        tx_d     = 1'b0;
                        state_d  = START;
                    end else begin
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule
